// File: rtl/fpu_addsub_pipe_if.sv
// Operand/result handshake bundle for fpu_addsub_pipe.
// The unit takes the slave side and the operand source takes the master side.
interface fpu_addsub_pipe_if #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 25
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_A_in;
    logic [W-1:0] op_B_in;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_out;
    logic [3:0]   status_out;

    modport master (
        output in_valid, op_A_in, op_B_in, op_sub, out_ready,
        input  in_ready, out_valid, data_out, status_out
    );

    modport slave (
        input  in_valid, op_A_in, op_B_in, op_sub, out_ready,
        output in_ready, out_valid, data_out, status_out
    );
endinterface

// File: rtl/fpu_addsub_pipe.sv
// Fixed-latency {sign, exp, mantissa} add/subtract with round-to-nearest-even and one-hot status.
// Define FPU_SUB_EN to honour op_sub; without it the unit only adds.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// ALIGN | swap so the larger exponent leads, shift the smaller mantissa, detect zero operands
// OPER  | add or subtract aligned magnitudes
// NORM  | carry shift-right or leading-zero shift-left
// ROUND | round-to-nearest-even on G/R/S
// DONE  | first cycle builds result and status, then holds until out_ready
module fpu_addsub_pipe #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 25
) (
    input  logic              clock100KHz,
    input  logic              reset,
    fpu_addsub_pipe_if.slave  bus
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int DW  = MAN_W + 4;
    localparam int EW  = EXP_W + 2;
    localparam int LZW = $clog2(DW + 1);

    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);

`ifdef FPU_SUB_EN
    localparam logic SUB_EN = 1'b1;
`else
    localparam logic SUB_EN = 1'b0;
`endif

    localparam logic [3:0] ST_EXACT   = 4'b0001;
    localparam logic [3:0] ST_INEXACT = 4'b0010;
    localparam logic [3:0] ST_OVF     = 4'b0100;
    localparam logic [3:0] ST_UNF     = 4'b1000;

    typedef enum logic [2:0] {IDLE, ALIGN, OPER, NORM, ROUND, DONE} state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           a_q, a_d, b_q, b_d;
    logic                   sub_q, sub_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [W-1:0]           data_q, data_d;
    logic [3:0]             status_q, status_d;
    logic                   byp_q, byp_d;
    logic [W-1:0]           byp_word_q, byp_word_d;
    logic                   sa_q, sa_d, sb_q, sb_d;
    logic [DW-1:0]          ma_q, ma_d, mb_q, mb_d;
    logic                   sign_q, sign_d;
    logic signed [EW-1:0]   exp_q, exp_d;
    logic [DW:0]            mag_q, mag_d;
    logic [MAN_W-1:0]       rm_q, rm_d;
    logic                   inexact_q, inexact_d;
    logic                   zero_q, zero_d;

    logic                   eff_sb;
    logic [EXP_W-1:0]       exp_a, exp_b, exp_big, exp_sml, diff;
    logic [MAN_W-1:0]       man_big, man_sml;
    logic                   s_big, s_sml, swap;
    logic [DW-1:0]          ext, shifted;
    logic [LZW-1:0]         lz;
    logic                   g, r, s, inc;
    logic [MAN_W+1:0]       rsum;

    function automatic logic [LZW-1:0] lzc_f(input logic [DW-1:0] v);
        lzc_f = LZW'(DW);
        for (int i = 0; i < DW; i++) begin
            if (v[i]) lzc_f = LZW'(DW - 1 - i);
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        status_d    = status_q;
        byp_d       = byp_q;
        byp_word_d  = byp_word_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mag_d       = mag_q;
        rm_d        = rm_q;
        inexact_d   = inexact_q;
        zero_d      = zero_q;

        eff_sb  = b_q[W-1] ^ (sub_q & SUB_EN);
        exp_a   = a_q[W-2:MAN_W];
        exp_b   = b_q[W-2:MAN_W];
        swap    = exp_b > exp_a;
        exp_big = swap ? exp_b : exp_a;
        exp_sml = swap ? exp_a : exp_b;
        man_big = swap ? b_q[MAN_W-1:0] : a_q[MAN_W-1:0];
        man_sml = swap ? a_q[MAN_W-1:0] : b_q[MAN_W-1:0];
        s_big   = swap ? eff_sb : a_q[W-1];
        s_sml   = swap ? a_q[W-1] : eff_sb;
        diff    = exp_big - exp_sml;
        ext     = {1'b1, man_sml, 3'b000};
        shifted = '0;
        lz      = lzc_f(mag_q[DW-1:0]);
        g       = mag_q[2];
        r       = mag_q[1];
        s       = mag_q[0];
        inc     = g & (r | s | mag_q[3]);
        rsum    = {1'b0, mag_q[DW-1:3]} + (MAN_W+2)'(inc);

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.op_A_in;
                    b_d        = bus.op_B_in;
                    sub_d      = bus.op_sub;
                    in_ready_d = 1'b0;
                    state_d    = ALIGN;
                end
            end
            ALIGN: begin
                // Beyond G/R the smaller operand only contributes a sticky bit
                if (32'(diff) > 32'(MAN_W + 2)) begin
                    shifted[0] = 1'b1;
                end else begin
                    shifted    = ext >> diff;
                    shifted[0] = shifted[0] | (|(ext & ~({DW{1'b1}} << diff)));
                end
                ma_d  = {1'b1, man_big, 3'b000};
                mb_d  = shifted;
                sa_d  = s_big;
                sb_d  = s_sml;
                exp_d = $signed({2'b00, exp_big});
                byp_d = (exp_a == '0) || (exp_b == '0);
                if ((exp_a == '0) && (exp_b == '0)) byp_word_d = '0;
                else if (exp_b == '0)               byp_word_d = a_q;
                else                                byp_word_d = {eff_sb, b_q[W-2:0]};
                state_d = OPER;
            end
            OPER: begin
                if (sa_q == sb_q) begin
                    mag_d  = {1'b0, ma_q} + {1'b0, mb_q};
                    sign_d = sa_q;
                end else if (ma_q >= mb_q) begin
                    mag_d  = {1'b0, ma_q - mb_q};
                    sign_d = sa_q;
                end else begin
                    mag_d  = {1'b0, mb_q - ma_q};
                    sign_d = sb_q;
                end
                state_d = NORM;
            end
            NORM: begin
                zero_d = (mag_q == '0);
                if (mag_q[DW]) begin
                    mag_d = {2'b00, mag_q[DW:2], mag_q[1] | mag_q[0]};
                    exp_d = exp_q + EXP_ONE;
                end else begin
                    mag_d = {1'b0, mag_q[DW-1:0] << lz};
                    exp_d = exp_q - $signed({{(EW-LZW){1'b0}}, lz});
                end
                state_d = ROUND;
            end
            ROUND: begin
                if (rsum[MAN_W+1]) begin
                    rm_d  = rsum[MAN_W:1];
                    exp_d = exp_q + EXP_ONE;
                end else begin
                    rm_d  = rsum[MAN_W-1:0];
                end
                inexact_d = g | r | s;
                state_d   = DONE;
            end
            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    if (byp_q) begin
                        data_d   = byp_word_q;
                        status_d = ST_EXACT;
                    end else if (zero_q) begin
                        data_d   = '0;
                        status_d = ST_EXACT;
                    end else if (exp_q >= EXP_MAX) begin
                        data_d   = '0;
                        status_d = ST_OVF;
                    end else if (exp_q <= EXP_ZERO) begin
                        data_d   = '0;
                        status_d = ST_UNF;
                    end else begin
                        data_d   = {sign_q, exp_q[EXP_W-1:0], rm_q};
                        status_d = inexact_q ? ST_INEXACT : ST_EXACT;
                    end
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            status_q    <= '0;
            byp_q       <= 1'b0;
            byp_word_q  <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            ma_q        <= '0;
            mb_q        <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mag_q       <= '0;
            rm_q        <= '0;
            inexact_q   <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            status_q    <= status_d;
            byp_q       <= byp_d;
            byp_word_q  <= byp_word_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mag_q       <= mag_d;
            rm_q        <= rm_d;
            inexact_q   <= inexact_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.data_out   = data_q;
    assign bus.status_out = status_q;

endmodule
